// File: rtl/regfile_sb.sv
// Parametrised 2-read/1-write register file with same-cycle write bypass,
// link-register writes and a per-register busy scoreboard for RAW stalls.
module regfile_sb #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 5,
    parameter int INIT_STRIDE = 4,
    parameter int LINK_REG    = 31,
    parameter bit ZERO_REG_EN = 1'b1
) (
    input  logic              clkin,
    input  logic              reset,
    input  logic [ADDR_W-1:0] RsAddr,
    input  logic [ADDR_W-1:0] RtAddr,
    output logic [DATA_W-1:0] RsData,
    output logic [DATA_W-1:0] RtData,
    input  logic              regWriteEn,
    input  logic              linkEn,
    input  logic [ADDR_W-1:0] regWriteAddr,
    input  logic [DATA_W-1:0] regWriteData,
    input  logic              issueValid,
    input  logic [ADDR_W-1:0] issueAddr,
    input  logic              wbClear,
    output logic              RsBusy,
    output logic              RtBusy,
    output logic              stall,
    output logic [ADDR_W:0]   busyCount
);

    localparam int                NUM_REGS  = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] LINK_ADDR = ADDR_W'(LINK_REG);
    localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [ADDR_W:0]     busy_cnt;
    logic [ADDR_W-1:0]   waddr;
    logic                wr_en;
    logic                clr_en;
    logic                set_en;
    logic                cnt_inc;
    logic                cnt_dec;

    function automatic logic [DATA_W-1:0] init_val(input int idx);
        return DATA_W'(idx * INIT_STRIDE);
    endfunction

    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return ZERO_REG_EN && (a == '0);
    endfunction

    // Zero-register check comes first so the bypass can never leak into reg 0.
    function automatic logic [DATA_W-1:0] read_port(
        input logic [ADDR_W-1:0] a,
        input logic [DATA_W-1:0] stored,
        input logic              byp_en,
        input logic [ADDR_W-1:0] byp_addr,
        input logic [DATA_W-1:0] byp_data
    );
        if (is_zero(a))
            return '0;
        else if (byp_en && (byp_addr == a))
            return byp_data;
        else
            return stored;
    endfunction

    always_comb begin
        waddr   = linkEn ? LINK_ADDR : regWriteAddr;
        wr_en   = regWriteEn && !is_zero(waddr);
        clr_en  = wr_en && wbClear;
        set_en  = issueValid && !is_zero(issueAddr);
        // A set on an idle register counts up; a clear only counts down when
        // it really drops a busy bit and is not overridden by a same-address set.
        cnt_inc = set_en && !busy[issueAddr];
        cnt_dec = clr_en && busy[waddr] && !(set_en && (issueAddr == waddr));
    end

    always_comb begin
        RsData = read_port(RsAddr, regs[RsAddr], regWriteEn, waddr, regWriteData);
        RtData = read_port(RtAddr, regs[RtAddr], regWriteEn, waddr, regWriteData);
    end

    always_ff @(posedge clkin or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= init_val(i);
        end else if (wr_en) begin
            regs[waddr] <= regWriteData;
        end
    end

    // Set is applied after clear so a new producer wins on a shared address.
    always_ff @(posedge clkin or negedge reset) begin
        if (!reset) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            if (clr_en)
                busy[waddr] <= 1'b0;
            if (set_en)
                busy[issueAddr] <= 1'b1;
            case ({cnt_inc, cnt_dec})
                2'b10:   busy_cnt <= busy_cnt + CNT_ONE;
                2'b01:   busy_cnt <= busy_cnt - CNT_ONE;
                default: busy_cnt <= busy_cnt;
            endcase
        end
    end

    assign RsBusy    = busy[RsAddr];
    assign RtBusy    = busy[RtAddr];
    assign stall     = RsBusy | RtBusy;
    assign busyCount = busy_cnt;

endmodule
